core_input_packer: RTL and testbench

CORE_INPUT_PACKER -- requirements
Module: core_input_packer

---
 rtl/core_input_packer.sv | 189 ++++++++++++++++++
 tb/tb_core_input_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_input_packer.sv
// Packs a byte stream into 32-bit little-endian words of a 16-word block buffer and
// appends 0x80 padding, zero fill and a 32-bit big-endian bit count in word 15.
module core_input_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] dout,
  output logic        blk_ready,
  output logic        blk_last,
  input  logic        blk_ack
);

  typedef enum logic [2:0] {StData, StPad, StZero, StLen, StWaitAck} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pad_pending_q, pad_pending_d;
  logic        len_pending_q, len_pending_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [31:0] dout_q, dout_d;
  logic        len_wr_q, len_wr_d;
  logic        blk_ready_q, blk_ready_d;
  logic        blk_last_q, blk_last_d;

  logic        ack;
  logic [31:0] bits;

  assign ack  = blk_ack & blk_ready_q;
  assign bits = {13'd0, cnt_q, 3'd0};

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    lane_d        = lane_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    pad_pending_d = pad_pending_q;
    len_pending_d = len_pending_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    dout_d        = dout_q;
    len_wr_d      = 1'b0;
    blk_ready_d   = blk_ready_q;
    blk_last_d    = blk_last_q;

    // blk_ready follows the registered word-15 write by one cycle
    if (wr_en_q && (wr_addr_q == 4'd15)) begin
      blk_ready_d = 1'b1;
      blk_last_d  = len_wr_q;
    end else if (ack) begin
      blk_ready_d = 1'b0;
      blk_last_d  = 1'b0;
    end

    unique case (state_q)
      StData: begin
        if (in_valid) begin
          cnt_d                         = cnt_q + 16'd1;
          word_d[{lane_q, 3'b000} +: 8] = in_data;
          lane_d                        = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            dout_d    = {in_data, word_q[23:0]};
            addr_d    = addr_q + 4'd1;
            word_d    = 32'd0;
          end
          if ((lane_q == 2'd3) && (addr_q == 4'd15)) begin
            state_d       = StWaitAck;
            pad_pending_d = in_last;
          end else if (in_last) begin
            state_d = StPad;
          end
        end
      end
      StPad: begin
        wr_en_d       = 1'b1;
        wr_addr_d     = addr_q;
        dout_d        = word_q | (32'h80 << {lane_q, 3'b000});
        addr_d        = addr_q + 4'd1;
        word_d        = 32'd0;
        lane_d        = 2'd0;
        pad_pending_d = 1'b0;
        if (addr_q == 4'd15) begin
          state_d       = StWaitAck;
          len_pending_d = 1'b1;
        end else if (addr_q == 4'd13) begin
          state_d = StLen;
        end else begin
          state_d = StZero;
        end
      end
      StZero: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        dout_d    = 32'd0;
        addr_d    = addr_q + 4'd1;
        if (addr_q == 4'd15) begin
          state_d       = StWaitAck;
          len_pending_d = 1'b1;
        end else if (addr_q == 4'd13) begin
          state_d = StLen;
        end
      end
      StLen: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        addr_d    = addr_q + 4'd1;
        dout_d    = 32'd0;
        if (addr_q == 4'd15) begin
          // Bit count goes out most-significant byte first in lane 0
          dout_d   = {bits[7:0], bits[15:8], bits[23:16], bits[31:24]};
          len_wr_d = 1'b1;
          state_d  = StWaitAck;
        end
      end
      StWaitAck: begin
        if (ack) begin
          if (blk_last_q) begin
            state_d       = StData;
            cnt_d         = 16'd0;
            word_d        = 32'd0;
            lane_d        = 2'd0;
            addr_d        = 4'd0;
            pad_pending_d = 1'b0;
            len_pending_d = 1'b0;
          end else if (pad_pending_q) begin
            state_d = StPad;
          end else if (len_pending_q) begin
            state_d       = StZero;
            len_pending_d = 1'b0;
          end else begin
            state_d = StData;
          end
        end
      end
      default: state_d = StData;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StData;
      word_q        <= 32'd0;
      lane_q        <= 2'd0;
      addr_q        <= 4'd0;
      cnt_q         <= 16'd0;
      pad_pending_q <= 1'b0;
      len_pending_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 4'd0;
      dout_q        <= 32'd0;
      len_wr_q      <= 1'b0;
      blk_ready_q   <= 1'b0;
      blk_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      lane_q        <= lane_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      pad_pending_q <= pad_pending_d;
      len_pending_q <= len_pending_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      dout_q        <= dout_d;
      len_wr_q      <= len_wr_d;
      blk_ready_q   <= blk_ready_d;
      blk_last_q    <= blk_last_d;
    end
  end

  assign in_ready  = (state_q == StData);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign dout      = dout_q;
  assign blk_ready = blk_ready_q;
  assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_core_input_packer.sv
// Random-traffic bench: a byte-level padding model predicts every block the packer
// should hand over, checked against a mirror of the 16x32 buffer.
module tb_core_input_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] dout;
  logic        blk_ready;
  logic        blk_last;
  logic        blk_ack;

  core_input_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .dout      (dout),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .blk_ack   (blk_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    bit           last;
    bit           next_rdy;
  } blk_t;

  blk_t        exp_q[$];
  logic [31:0] mem[16];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: standard byte-stream padding, blocks cut every 64 bytes, little-endian words
  task automatic model_msg(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [31:0] nbits;
    blk_t        e;
    int          nblk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    nbits = 32'(m.size() * 8);
    repeat (4) p.push_back(8'h00);
    p.push_back(nbits[31:24]);
    p.push_back(nbits[23:16]);
    p.push_back(nbits[15:8]);
    p.push_back(nbits[7:0]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++)
        e.data[32*w +: 32] = {p[b*64+4*w+3], p[b*64+4*w+2], p[b*64+4*w+1], p[b*64+4*w]};
      e.last     = (b == nblk - 1);
      e.next_rdy = e.last || (64 * (b + 1) < m.size());
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int guard = 0;
    bit done  = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    while (!done && guard < 500) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      done     = in_ready;
      guard++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: in_ready stayed 0, expected 1 within 500 cycles");
    end
  endtask

  task automatic send_msg(input logic [7:0] m[$]);
    int guard = 0;
    model_msg(m);
    for (int i = 0; i < m.size(); i++) send_byte(m[i], i == m.size() - 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    while ((exp_q.size() != 0 || blk_ready) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0 || blk_ready) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d blocks outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic rand_msg(input int len);
    logic [7:0] m[$];
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    send_msg(m);
  endtask

  // Core-side consumer: acks each block after a random delay, plus stray acks when idle
  initial begin
    int ack_wait = 0;
    blk_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        blk_ack = 1'b0;
      end else if (blk_ready) begin
        if (ack_wait == 0) begin
          blk_ack = 1'b1;
        end else begin
          ack_wait--;
          blk_ack = 1'b0;
        end
      end else begin
        blk_ack  = ($urandom_range(0, 7) == 0);
        ack_wait = $urandom_range(0, 3);
      end
    end
  end

  // Compare process: buffer mirror and per-cycle protocol checks
  initial begin
    bit   prev_rdy = 0;
    bit   pend_rdy = 0;
    blk_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("write_during_rst", 32'(wr_en), 32'd0);
        prev_rdy = 0;
      end else begin
        if (wr_en) mem[wr_addr] = dout;
        if (blk_ready) begin
          check("in_ready_while_busy", 32'(in_ready), 32'd0);
          check("write_while_busy", 32'(wr_en), 32'd0);
        end
        if (blk_ready && !prev_rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_block: blk_ready=1, expected no block");
          end else begin
            e = exp_q.pop_front();
            for (int w = 0; w < 16; w++)
              check($sformatf("blk_word%0d", w), mem[w], e.data[32*w +: 32]);
            check("blk_last", 32'(blk_last), 32'(e.last));
            pend_rdy = e.next_rdy;
          end
        end
        if (!blk_ready && prev_rdy) check("in_ready_after_ack", 32'(in_ready), 32'(pend_rdy));
        prev_rdy = blk_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] abc[$];
    logic [7:0] m[$];
    int         base;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    abc      = '{8'h61, 8'h62, 8'h63};
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_blk_ready", 32'(blk_ready), 32'd0);
    check("rst_blk_last", 32'(blk_last), 32'd0);
    rst = 1'b0;

    // Pin the model against hand-computed blocks
    base = exp_q.size();
    model_msg(abc);
    check("model_abc_nblk", 32'(exp_q.size() - base), 32'd1);
    check("model_abc_w0", exp_q[base].data[31:0], 32'h80636261);
    check("model_abc_w15", exp_q[base].data[511:480], 32'h18000000);
    m = {};
    repeat (56) m.push_back(8'h11);
    model_msg(m);
    check("model_56_w14", exp_q[base+1].data[479:448], 32'h00000080);
    check("model_56_last0", 32'(exp_q[base+1].last), 32'd0);
    check("model_56_w15b", exp_q[base+2].data[511:480], 32'hC0010000);
    repeat (8) m.push_back(8'h22);
    model_msg(m);
    check("model_64_w0b", exp_q[base+4].data[31:0], 32'h00000080);
    check("model_64_w15b", exp_q[base+4].data[511:480], 32'h00020000);
    exp_q = {};

    send_msg(abc);
    rand_msg(56);
    rand_msg(64);
    rand_msg(128);

    // Abandon a message partway and restart
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;
    send_msg(abc);

    foreach (abc[i]) abc[i] = abc[i];
    for (int i = 0; i < 14; i++) begin
      int lens[14] = '{1, 4, 52, 53, 55, 57, 59, 60, 63, 119, 120, 121, 200, 0};
      rand_msg(lens[i] == 0 ? $urandom_range(1, 180) : lens[i]);
    end
    repeat (4) rand_msg($urandom_range(1, 250));

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
